// File: rtl/idu32_encoder_pkg.sv
// Shared constants for the RV32 instruction encoder.
// Contents: format codes (R..J), base opcode constants, the buffered output
// word type, and a signed-range helper used by the optional immediate check.
package idu32_encoder_pkg;

  // Format codes carried on in_fmt; 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // RV32I base opcodes.
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // One buffered output word.
  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_word_t;

  // True when v is representable as a signed value of the given bit width:
  // everything from the sign bit upward must be all zeros or all ones.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/idu32_enc_pack.sv
// Combinational field packing for RV32 R/I/S/B/U/J formats.
// Ports:
//   fmt, opcode, funct3, funct7, rd, rs1, rs2, imm : instruction fields
//   inst : packed 32-bit instruction (0 for illegal fmt)
//   err  : illegal fmt, or (with IDU32_IMM_CHECK_EN) unrepresentable imm
// Optional feature macro: IDU32_IMM_CHECK_EN enables the immediate range check.
// The encoding itself is always the truncated one, regardless of the check.
module idu32_enc_pack
  import idu32_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

`ifdef IDU32_IMM_CHECK_EN
  logic range_ok;
`endif

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (fmt)
      FMT_R:   inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   inst = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   inst = {imm[31:12], rd, opcode};
      FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: err  = 1'b1;
    endcase
`ifdef IDU32_IMM_CHECK_EN
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok = fits_signed(imm, 12);
      FMT_B:        range_ok = fits_signed(imm, 13) && !imm[0];
      FMT_J:        range_ok = fits_signed(imm, 21) && !imm[0];
      FMT_U:        range_ok = (imm[11:0] == '0);
      default:      range_ok = 1'b1;
    endcase
    if (!range_ok) err = 1'b1;
`endif
  end

endmodule

// File: rtl/idu32_encoder.sv
// RV32 instruction encoder with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid/in_ready    : field bundle handshake
//   in_fmt..in_imm       : instruction fields (fmt 0=R 1=I 2=S 3=B 4=U 5=J)
//   out_valid/out_ready  : encoded word handshake
//   out_inst, out_err    : encoded instruction and error flag
//   enc_count            : completed output handshakes, wraps mod 2^CNT_W
// Optional feature macro: IDU32_IMM_CHECK_EN (immediate range check, in
// idu32_enc_pack). Buffering is a main output register plus one skid entry;
// in_ready depends only on registered state.
module idu32_encoder
  import idu32_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  enc_word_t enc_word;
  enc_word_t main_q;
  enc_word_t skid_q;
  logic      main_valid;
  logic      skid_valid;
  logic      push;
  logic      pop;

  idu32_enc_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .inst   (enc_word.inst),
    .err    (enc_word.err)
  );

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_inst  = main_q.inst;
  assign out_err   = main_q.err;
  assign push      = in_valid && in_ready;
  assign pop       = main_valid && out_ready;

  // A full skid blocks input, so "pop with skid full" never coincides with
  // a push; otherwise a push lands in main if main is free or draining this
  // cycle, and in the skid entry only when main is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      enc_count  <= '0;
    end else begin
      if (pop) enc_count <= enc_count + CNT_W'(1);
      if (pop && skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (push && (!main_valid || pop)) begin
        main_q     <= enc_word;
        main_valid <= 1'b1;
      end else if (push) begin
        skid_q     <= enc_word;
        skid_valid <= 1'b1;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idu32_encoder.sv
module tb_idu32_encoder;

`ifdef IDU32_IMM_CHECK_EN
  localparam bit IMM_CHK = 1'b1;
`else
  localparam bit IMM_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [31:0] enc_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [32:0] exp_q[$];     // {err, inst} in acceptance order
  int unsigned exp_cnt = 0;  // expected enc_count
  int unsigned acc_cnt = 0;  // accepted bundles

  idu32_encoder #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built from bit arithmetic on the field definitions.
  function automatic logic [32:0] ref_enc(input int unsigned f, input int unsigned op,
      input int unsigned f3, input int unsigned f7, input int unsigned rd,
      input int unsigned rs1, input int unsigned rs2, input int unsigned imm);
    int unsigned w;
    int          s;
    bit          range_bad;
    s = int'(imm);
    w = 0;
    range_bad = 0;
    case (f)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        range_bad = (s < -2048) || (s > 2047);
      end
      2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 32'h1F) << 7) | op;
        range_bad = (s < -2048) || (s > 2047);
      end
      3: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
            | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 11) & 1) << 7) | op;
        range_bad = (s < -4096) || (s > 4095) || ((imm & 1) != 0);
      end
      4: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        range_bad = (imm & 32'hFFF) != 0;
      end
      5: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        range_bad = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((imm & 1) != 0);
      end
      default: return {1'b1, 32'h0};
    endcase
    return {IMM_CHK && range_bad, w};
  endfunction

  // Scoreboard: sampled on the falling edge, predicts the rising edge that follows.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("enc_count", enc_count, exp_cnt);
      if (out_valid && exp_q.size() > 0) begin
        check("out_inst", out_inst, exp_q[0][31:0]);
        check("out_err", out_err, exp_q[0][32]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc(in_fmt, in_opcode, in_funct3, in_funct7,
                                in_rd, in_rs1, in_rs2, in_imm));
        acc_cnt++;
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_inst"}, out_inst, 32'h0);
    check({tag, "_out_err"}, out_err, 1'b0);
    check({tag, "_enc_count"}, enc_count, 32'h0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    acc_cnt = 0;
    #1;
    check_reset_state("rst");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Single bundle into an empty pipe; word must be visible one cycle after acceptance.
  task automatic one_shot(input string tag, input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp_inst,
      input logic exp_err);
    out_ready = 1'b1;
    drive(f, op, f3, f7, rd, rs1, rs2, imm);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, out_err, exp_err);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    in_valid = 1'b0;
    #3;
    check_reset_state("por");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Known encodings.
    one_shot("i_addi", 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    one_shot("r_add", 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    one_shot("s_sw", 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    one_shot("b_neg4", 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    one_shot("j_2048", 3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    one_shot("u_lui", 3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    one_shot("i_2048", 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, IMM_CHK);
    one_shot("fmt7", 3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0000_0000, 1'b1);
    one_shot("fmt6", 3'd6, 7'h33, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'd0, 32'h0000_0000, 1'b1);
    check("enc_count_direct", enc_count, 32'd9);

    // Backpressure: three back-to-back pushes with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    next_cycle();
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2);
    next_cycle();
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3);
    next_cycle();
    @(negedge clk);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_accepted", acc_cnt, 32'd2);
    check("bp_hold_inst", out_inst, 32'h0010_0093);
    next_cycle();
    out_ready = 1'b1;
    begin
      bit done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        next_cycle();
        if (acc_cnt == 3) done = 1;
      end
      check("bp_third_accepted", done, 1'b1);
    end
    in_valid = 1'b0;
    repeat (4) next_cycle();
    check("bp_enc_count", enc_count, 32'd3);

    // Reset with both entries full.
    out_ready = 1'b0;
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd4, 5'd5, 5'd6, 32'd0);
    next_cycle();
    drive(3'd4, 7'h37, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check_reset_state("mid");
    next_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) next_cycle();
    check("post_rst_valid", out_valid, 1'b0);

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 4400)) - 2200);
        1: imm = 32'($signed($urandom_range(0, 9000)) - 4500) & ~32'h1;
        2: imm = $urandom() & 32'hFFFF_F000;
        default: imm = $urandom();
      endcase
      drive(3'($urandom_range(0, 7)), 7'($urandom()), 3'($urandom()), 7'($urandom()),
            5'($urandom()), 5'($urandom()), 5'($urandom()), imm);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      next_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) next_cycle();
    check("drain_empty", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
